// File: rtl/arc4_ctrl.sv
`default_nettype none
// arc4_ctrl: runs the init, ksa and optional prga engines in sequence on one start
// request, and routes the single S-memory port to whichever engine is active.
module arc4_ctrl #(
   parameter int TIMEOUT = 4096,
   parameter int CW      = $clog2(TIMEOUT)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        ksa_only,
   input  logic [23:0] key,
   output logic        rdy,
   output logic        done,
   output logic        err,
   output logic [1:0]  phase,
   output logic [23:0] key_q,
   output logic        en_i,
   output logic        en_k,
   output logic        en_p,
   input  logic        rdy_i,
   input  logic        rdy_k,
   input  logic        rdy_p,
   input  logic [7:0]  addr_i,
   input  logic [7:0]  wrdata_i,
   input  logic        wren_i,
   input  logic [7:0]  addr_k,
   input  logic [7:0]  wrdata_k,
   input  logic        wren_k,
   input  logic [7:0]  addr_p,
   input  logic [7:0]  wrdata_p,
   input  logic        wren_p,
   output logic [7:0]  s_addr,
   output logic [7:0]  s_wrdata,
   output logic        s_wren
);

   // Each phase's REQ/GO/BUSY/WAIT states are consecutive, and each WAIT is
   // followed by the next phase's REQ (or DONE), so "next state" is state + 1.
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_I_REQ  = 4'd1,
      S_I_GO   = 4'd2,
      S_I_BUSY = 4'd3,
      S_I_WAIT = 4'd4,
      S_K_REQ  = 4'd5,
      S_K_GO   = 4'd6,
      S_K_BUSY = 4'd7,
      S_K_WAIT = 4'd8,
      S_P_REQ  = 4'd9,
      S_P_GO   = 4'd10,
      S_P_BUSY = 4'd11,
      S_P_WAIT = 4'd12,
      S_DONE   = 4'd13,
      S_ERR    = 4'd14
   } state_t;

   state_t        state;
   logic [CW-1:0] wd;
   logic          ko_q;
   logic          rdy_sel;
   logic          wd_max;
   logic          last;

   always_comb begin
      case (phase)
         2'd1:    rdy_sel = rdy_i;
         2'd2:    rdy_sel = rdy_k;
         2'd3:    rdy_sel = rdy_p;
         default: rdy_sel = 1'b0;
      endcase
   end

   assign wd_max = (wd == CW'(TIMEOUT - 1));
   assign last   = (phase == 2'd3) || ((phase == 2'd2) && ko_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         wd    <= '0;
         ko_q  <= 1'b0;
         rdy   <= 1'b1;
         done  <= 1'b0;
         err   <= 1'b0;
         phase <= 2'd0;
         key_q <= 24'd0;
         en_i  <= 1'b0;
         en_k  <= 1'b0;
         en_p  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en) begin
                  state <= S_I_REQ;
                  rdy   <= 1'b0;
                  phase <= 2'd1;
                  key_q <= key;
                  ko_q  <= ksa_only;
                  err   <= 1'b0;
                  wd    <= '0;
               end
            end
            S_I_REQ, S_K_REQ, S_P_REQ: begin
               if (rdy_sel) begin
                  state <= state_t'(state + 4'd1);
                  wd    <= '0;
                  en_i  <= (phase == 2'd1);
                  en_k  <= (phase == 2'd2);
                  en_p  <= (phase == 2'd3);
               end else if (wd_max) begin
                  state <= S_ERR;
                  err   <= 1'b1;
                  phase <= 2'd0;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            S_I_GO, S_K_GO, S_P_GO: begin
               state <= state_t'(state + 4'd1);
               en_i  <= 1'b0;
               en_k  <= 1'b0;
               en_p  <= 1'b0;
            end
            // Require rdy to drop first so a stale rdy cannot end the phase early.
            S_I_BUSY, S_K_BUSY, S_P_BUSY: begin
               if (!rdy_sel) begin
                  state <= state_t'(state + 4'd1);
                  wd    <= wd + 1'b1;
               end else if (wd_max) begin
                  state <= S_ERR;
                  err   <= 1'b1;
                  phase <= 2'd0;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            S_I_WAIT, S_K_WAIT, S_P_WAIT: begin
               if (rdy_sel) begin
                  if (last) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     phase <= 2'd0;
                  end else begin
                     state <= state_t'(state + 4'd1);
                     phase <= phase + 2'd1;
                     wd    <= '0;
                  end
               end else if (wd_max) begin
                  state <= S_ERR;
                  err   <= 1'b1;
                  phase <= 2'd0;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               rdy   <= 1'b1;
               state <= S_IDLE;
            end
            S_ERR: begin
               rdy   <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               rdy   <= 1'b1;
               phase <= 2'd0;
            end
         endcase
      end
   end

   always_comb begin
      s_addr   = 8'd0;
      s_wrdata = 8'd0;
      s_wren   = 1'b0;
      case (phase)
         2'd1: begin
            s_addr   = addr_i;
            s_wrdata = wrdata_i;
            s_wren   = wren_i;
         end
         2'd2: begin
            s_addr   = addr_k;
            s_wrdata = wrdata_k;
            s_wren   = wren_k;
         end
         2'd3: begin
            s_addr   = addr_p;
            s_wrdata = wrdata_p;
            s_wren   = wren_p;
         end
         default: begin
            s_addr   = 8'd0;
            s_wrdata = 8'd0;
            s_wren   = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_arc4_ctrl.sv
`default_nettype none
// tb_arc4_ctrl: random engine traffic compared every cycle with a behavioural sequencer
// model, plus literal checks of ordering, latency, watchdog and reset behaviour.
module tb_arc4_ctrl;
   localparam int TO_MAIN = 1024;
   localparam int TO_WD   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        en, ksa_only;
   logic [23:0] key;
   logic        rdy, done, err;
   logic [1:0]  phase;
   logic [23:0] key_q;
   logic        en_i, en_k, en_p;
   logic        rdy_i, rdy_k, rdy_p;
   logic [7:0]  addr_i, wrdata_i, addr_k, wrdata_k, addr_p, wrdata_p;
   logic        wren_i, wren_k, wren_p;
   logic [7:0]  s_addr, s_wrdata;
   logic        s_wren;

   arc4_ctrl #(.TIMEOUT(TO_MAIN)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .ksa_only(ksa_only), .key(key),
      .rdy(rdy), .done(done), .err(err), .phase(phase), .key_q(key_q),
      .en_i(en_i), .en_k(en_k), .en_p(en_p),
      .rdy_i(rdy_i), .rdy_k(rdy_k), .rdy_p(rdy_p),
      .addr_i(addr_i), .wrdata_i(wrdata_i), .wren_i(wren_i),
      .addr_k(addr_k), .wrdata_k(wrdata_k), .wren_k(wren_k),
      .addr_p(addr_p), .wrdata_p(wrdata_p), .wren_p(wren_p),
      .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
   );

   // Second instance with a short watchdog for the timeout scenario.
   logic        w_en, w_rdy, w_done, w_err;
   logic [1:0]  w_phase;
   logic [23:0] w_key_q;
   logic        w_en_i, w_en_k, w_en_p, w_rdy_i, w_rdy_k, w_rdy_p;
   logic [7:0]  w_s_addr, w_s_wrdata;
   logic        w_s_wren;

   arc4_ctrl #(.TIMEOUT(TO_WD)) dut_wd (
      .clk(clk), .rst_n(rst_n), .en(w_en), .ksa_only(1'b0), .key(24'hABCDEF),
      .rdy(w_rdy), .done(w_done), .err(w_err), .phase(w_phase), .key_q(w_key_q),
      .en_i(w_en_i), .en_k(w_en_k), .en_p(w_en_p),
      .rdy_i(w_rdy_i), .rdy_k(w_rdy_k), .rdy_p(w_rdy_p),
      .addr_i(8'h11), .wrdata_i(8'h22), .wren_i(1'b1),
      .addr_k(8'h33), .wrdata_k(8'h44), .wren_k(1'b1),
      .addr_p(8'h55), .wrdata_p(8'h66), .wren_p(1'b1),
      .s_addr(w_s_addr), .s_wrdata(w_s_wrdata), .s_wren(w_s_wren)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // ---------------- behavioural reference model ----------------
   // step: 0 waiting for engine ready, 1 enable cycle, 2 waiting for engine to go busy,
   // 3 waiting for engine to finish. m_end marks the single DONE/ERR cycle.
   logic        m_busy, m_end, m_done, m_err, m_ko;
   logic [1:0]  m_ph;
   int          m_step, m_wait;
   logic [23:0] m_key;

   function automatic logic owner_rdy(input logic [1:0] p);
      return (p == 2'd1) ? rdy_i : (p == 2'd2) ? rdy_k : (p == 2'd3) ? rdy_p : 1'b0;
   endfunction

   function automatic logic step_advances(input int step, input logic r);
      return (step == 1) ? 1'b1 : (step == 2) ? !r : r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_end <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_ko <= 1'b0;
         m_ph <= 2'd0; m_step <= 0; m_wait <= 0; m_key <= 24'd0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (en) begin
               m_busy <= 1'b1; m_ph <= 2'd1; m_step <= 0; m_wait <= 0;
               m_key <= key; m_ko <= ksa_only; m_err <= 1'b0;
            end
         end else if (m_end) begin
            m_busy <= 1'b0;
            m_end  <= 1'b0;
         end else if (step_advances(m_step, owner_rdy(m_ph))) begin
            case (m_step)
               0: begin m_step <= 1; m_wait <= 0; end
               1: m_step <= 2;
               2: begin m_step <= 3; m_wait <= m_wait + 1; end
               default: begin
                  if (m_ph == 2'd3 || (m_ph == 2'd2 && m_ko)) begin
                     m_ph <= 2'd0; m_end <= 1'b1; m_done <= 1'b1;
                  end else begin
                     m_ph <= m_ph + 2'd1; m_step <= 0; m_wait <= 0;
                  end
               end
            endcase
         end else if (m_wait == TO_MAIN - 1) begin
            m_ph <= 2'd0; m_end <= 1'b1; m_err <= 1'b1;
         end else begin
            m_wait <= m_wait + 1;
         end
      end
   end

   // ---------------- engines, compare process, event logs ----------------
   int   busy_len[3] = '{256, 768, 300};
   int   cnt[3], w_cnt[3];
   bit   pend[3];
   bit   stall_i, stall_k, force_kp, force_all, key_watch, saw_p3;
   int   cyc = 0, rdyk_rise = 0, done_cyc = 0, done_cnt = 0, iso_bad = 0, key_bad = 0;
   int   en_log[$], ph_log[$];
   logic [1:0] prev_ph = 2'd0;

   initial begin
      forever begin
         logic [2:0]  ev, exp_en;
         logic [16:0] exp_mux;
         logic        new_rk;
         @(negedge clk);
         cyc++;
         chk("rdy", rdy, !m_busy);
         chk("done", done, m_done);
         chk("err", err, m_err);
         chk("phase", phase, m_ph);
         chk("key_q", key_q, m_key);
         exp_en = (m_busy && !m_end && m_step == 1) ? (3'b001 << (m_ph - 2'd1)) : 3'b000;
         chk("en_vec", {en_p, en_k, en_i}, exp_en);
         case (m_ph)
            2'd1:    exp_mux = {wren_i, addr_i, wrdata_i};
            2'd2:    exp_mux = {wren_k, addr_k, wrdata_k};
            2'd3:    exp_mux = {wren_p, addr_p, wrdata_p};
            default: exp_mux = 17'd0;
         endcase
         chk("s_port", {s_wren, s_addr, s_wrdata}, exp_mux);

         if (en_i) en_log.push_back(1);
         if (en_k) en_log.push_back(2);
         if (en_p) en_log.push_back(3);
         if (phase !== prev_ph) begin ph_log.push_back(int'(phase)); prev_ph = phase; end
         if (phase == 2'd3) saw_p3 = 1'b1;
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (force_kp && phase == 2'd1 &&
             (s_wren !== wren_i || s_addr !== addr_i || s_wrdata !== wrdata_i)) iso_bad++;
         if (key_watch && !rdy && key_q !== 24'h00033C) key_bad++;

         ev = {en_p, en_k, en_i};
         for (int x = 0; x < 3; x++) begin
            if (!rst_n) begin
               cnt[x] = 0; pend[x] = 1'b0; w_cnt[x] = 0;
            end else begin
               if (cnt[x] > 0) cnt[x]--;
               if (pend[x]) begin pend[x] = 1'b0; cnt[x] = busy_len[x]; end
               if (ev[x]) pend[x] = 1'b1;
               if (w_cnt[x] > 0) w_cnt[x]--;
               if ({w_en_p, w_en_k, w_en_i} & (3'b001 << x)) w_cnt[x] = 3;
            end
         end
         rdy_i  = (cnt[0] == 0) && !stall_i;
         new_rk = (cnt[1] == 0);
         if (new_rk && !rdy_k) rdyk_rise = cyc;
         rdy_k  = new_rk;
         rdy_p  = (cnt[2] == 0);
         w_rdy_i = (w_cnt[0] == 0);
         w_rdy_k = (w_cnt[1] == 0) && !stall_k;
         w_rdy_p = (w_cnt[2] == 0);

         addr_i = 8'($urandom); wrdata_i = 8'($urandom); wren_i = force_all | 1'($urandom);
         addr_k = 8'($urandom); wrdata_k = 8'($urandom); wren_k = force_all | force_kp | 1'($urandom);
         addr_p = 8'($urandom); wrdata_p = 8'($urandom); wren_p = force_all | force_kp | 1'($urandom);
      end
   end

   task automatic clear_logs();
      en_log.delete(); ph_log.delete();
      prev_ph = 2'd0; done_cnt = 0; iso_bad = 0; key_bad = 0; saw_p3 = 1'b0;
   endtask

   function automatic int sig(input int q[$]);
      int s = 0;
      foreach (q[i]) s = s * 10 + q[i];
      return s;
   endfunction

   task automatic pulse_en(input logic [23:0] k, input logic ko);
      key = k; ksa_only = ko; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
      $fatal(1);
   end

   initial begin
      bit got;
      int kc, wd_done;
      en = 1'b0; ksa_only = 1'b0; key = 24'd0; w_en = 1'b0;
      stall_i = 1'b0; stall_k = 1'b0; force_kp = 1'b0; force_all = 1'b0; key_watch = 1'b0;
      rdy_i = 1'b1; rdy_k = 1'b1; rdy_p = 1'b1; w_rdy_i = 1'b1; w_rdy_k = 1'b1; w_rdy_p = 1'b1;
      addr_i = 8'd0; wrdata_i = 8'd0; wren_i = 1'b0; addr_k = 8'd0; wrdata_k = 8'd0; wren_k = 1'b0;
      addr_p = 8'd0; wrdata_p = 8'd0; wren_p = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ctl", {rdy, done, err, phase, en_i, en_k, en_p}, 8'b1000_0000);
      chk("rst_key_q", key_q, 24'd0);
      rst_n = 1'b1;

      // Idle: all engines writing, memory port stays quiet.
      force_all = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_s_port", {s_wren, s_addr, s_wrdata}, 17'd0);
      force_all = 1'b0;

      // Full run with isolation forcing and an ignored mid-run start request.
      clear_logs(); key_watch = 1'b1; force_kp = 1'b1;
      pulse_en(24'h00033C, 1'b0);
      chk("accept_phase", phase, 2'd1);
      repeat (100) @(negedge clk);
      pulse_en(24'hFFFFFF, 1'b0);
      key = 24'h00033C;
      wait_done(3000, got);
      chk("full_done_seen", got, 1);
      repeat (2) @(negedge clk);
      chk("full_rdy_back", rdy, 1);
      chk("full_en_order", sig(en_log), 123);
      chk("full_phase_seq", sig(ph_log), 1230);
      chk("full_done_count", done_cnt, 1);
      chk("full_key_stable", key_bad, 0);
      chk("init_isolation", iso_bad, 0);
      key_watch = 1'b0; force_kp = 1'b0;

      // KSA-only with init engine not ready for the first 10 cycles.
      clear_logs(); stall_i = 1'b1;
      pulse_en(24'($urandom), 1'b1);
      repeat (10) @(negedge clk);
      chk("stall_no_en_i", en_log.size(), 0);
      stall_i = 1'b0;
      wait_done(2000, got);
      chk("ko_done_seen", got, 1);
      repeat (2) @(negedge clk);
      chk("ko_en_order", sig(en_log), 12);
      chk("ko_no_phase3", saw_p3, 0);
      chk("ko_done_latency", (done_cyc - rdyk_rise >= 1) && (done_cyc - rdyk_rise <= 2), 1);

      // Reset asserted mid-KSA, then a fresh run.
      clear_logs();
      pulse_en(24'h123456, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (phase == 2'd2) begin got = 1'b1; break; end
      end
      chk("reach_ksa", got, 1);
      repeat (50) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_ctl", {rdy, done, err, phase, en_i, en_k, en_p}, 8'b1000_0000);
      chk("rst_mid_key_q", key_q, 24'd0);
      chk("rst_mid_s_port", {s_wren, s_addr, s_wrdata}, 17'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_en(24'h0A0B0C, 1'b1);
      wait_done(2000, got);
      chk("post_rst_done", got, 1);
      repeat (2) @(negedge clk);

      // Watchdog: KSA engine never becomes ready.
      stall_k = 1'b1; w_en = 1'b1;
      @(negedge clk);
      w_en = 1'b0;
      kc = 0; wd_done = 0; got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (w_done) wd_done++;
         if (w_err) begin got = 1'b1; break; end
         if (w_phase == 2'd2) kc++;
      end
      chk("wd_err_set", got, 1);
      chk("wd_ksa_cycles", kc, TO_WD);
      chk("wd_phase_zero", w_phase, 2'd0);
      @(negedge clk);
      chk("wd_rdy_back", w_rdy, 1);
      chk("wd_no_done", wd_done + int'(w_done), 0);
      stall_k = 1'b0;
      repeat (3) @(negedge clk);
      chk("wd_err_sticky", w_err, 1);
      w_en = 1'b1;
      @(negedge clk);
      w_en = 1'b0;
      chk("wd_err_cleared", w_err, 0);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (w_done) begin got = 1'b1; break; end
      end
      chk("wd_rerun_done", got, 1);
      chk("wd_rerun_no_err", w_err, 0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
